// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

   // Protocol phase of the target; ACK states cover the 9th SCL clock of a byte.
   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   // SDA level carried during the acknowledge bit.
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_regs_line_filter.sv
// One bus line: synchronizer chain, run-length glitch filter and edge detect.
// Pad-to-edge-pulse latency is SYNC_STAGES + FILTER_LEN clk cycles.
module i2c_line_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   prev_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Synchronizer chain; idle bus level is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= pad_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Accept a new level only after FILTER_LEN consecutive differing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (synced != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = synced;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Filtered level and its one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~prev_q;
   assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS byte registers with a pointer-then-data
// protocol, mirrored on an Avalon-MM slave port.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]  TARGET_ADDR = 7'h42,
   parameter int unsigned NUM_REGS    = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        scl_in,
   input  logic                        sda_in,
   output logic                        sda_oe,
   input  logic [$clog2(NUM_REGS)-1:0] address,
   input  logic                        chipselect,
   input  logic                        read,
   input  logic                        write,
   input  logic [7:0]                  writedata,
   output logic [7:0]                  readdata,
   output logic                        busy,
   output logic                        wr_event
);

   localparam int unsigned PW = $clog2(NUM_REGS);

   logic          scl_lvl, scl_rise, scl_fall;
   logic          sda_lvl, sda_rise, sda_fall;
   logic          start_cond, stop_cond;

   state_t        state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          wr_ev_q, wr_ev_d;
   logic          reg_we;
   logic [7:0]    rx_byte;
   logic [7:0]    readdata_q;
   logic [7:0]    regs_q [NUM_REGS];

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk    (clk),
      .reset  (reset),
      .pad_i  (scl_in),
      .level_o(scl_lvl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk    (clk),
      .reset  (reset),
      .pad_i  (sda_in),
      .level_o(sda_lvl),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;
   assign rx_byte    = {shift_q[6:0], sda_lvl};
   assign ptr_inc    = ptr_q + PW'(1);

   // Protocol engine. ACK states enter at the 8th SCL rise with bitcnt=8:
   // the next fall asserts SDA (bitcnt->9), the one after ends the ACK bit.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      wr_ev_d  = 1'b0;
      reg_we   = 1'b0;
      if (start_cond) begin
         state_d  = ADDR;
         bitcnt_d = '0;
         oe_d     = 1'b0;
      end else if (stop_cond) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ADDR: begin
               if (scl_rise) begin
                  shift_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     if (rx_byte[7:1] == TARGET_ADDR) begin
                        state_d = ADDR_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     oe_d     = 1'b1;
                     bitcnt_d = 4'd9;
                  end else begin
                     bitcnt_d = '0;
                     if (shift_q[0]) begin
                        shift_d = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        state_d = RD_DATA;
                     end else begin
                        oe_d    = 1'b0;
                        state_d = PTR;
                     end
                  end
               end
            end
            PTR: begin
               if (scl_rise) begin
                  shift_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     ptr_d   = rx_byte[PW-1:0];
                     state_d = PTR_ACK;
                  end
               end
            end
            PTR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     oe_d     = 1'b1;
                     bitcnt_d = 4'd9;
                  end else begin
                     oe_d     = 1'b0;
                     bitcnt_d = '0;
                     state_d  = WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd7) begin
                     reg_we  = 1'b1;
                     wr_ev_d = 1'b1;
                     ptr_d   = ptr_inc;
                     state_d = WR_ACK;
                  end
               end
            end
            RD_DATA: begin
               // bitcnt counts bits already clocked out; bit 7 may be driven
               // on entry (after address ACK) or on the first fall (after master ACK).
               if (scl_rise && bitcnt_q != 4'd8) begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bitcnt_q == 4'd0) begin
                     oe_d = ~shift_q[7];
                  end else if (bitcnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     state_d = RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oe_d    = ~shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == I2C_ACK) begin
                     ptr_d    = ptr_inc;
                     shift_d  = regs_q[ptr_inc];
                     bitcnt_d = '0;
                     state_d  = RD_DATA;
                  end else begin
                     oe_d    = 1'b0;
                     busy_d  = 1'b0;
                     state_d = IGNORE;
                  end
               end
            end
            IGNORE: begin
               oe_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   // Protocol state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         ptr_q    <= '0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         wr_ev_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         wr_ev_q  <= wr_ev_d;
      end
   end

   // Register file; the I2C write is issued last so it wins a same-cycle collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (chipselect && write) begin
            regs_q[address] <= writedata;
         end
         if (reg_we) begin
            regs_q[ptr_q] <= rx_byte;
         end
      end
   end

   // Registered Avalon read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= '0;
      end else if (chipselect && read) begin
         readdata_q <= regs_q[address];
      end
   end

   assign sda_oe   = oe_q;
   assign busy     = busy_q;
   assign wr_event = wr_ev_q;
   assign readdata = readdata_q;

endmodule
